// File: rtl/lstm_act_pkg.sv
// lstm_act_pkg: shared segment/mode enums, breakpoints and 16-fractional-bit coefficients for lstm_act_pwq.
package lstm_act_pkg;
    typedef enum logic [2:0] {SEG_LO, SEG_N3N1, SEG_N1Z, SEG_ZP1, SEG_P1P3, SEG_HI} seg_e;
    typedef enum logic {ACT_SIGMOID, ACT_TANH} act_mode_e;
    localparam int COEF_FRAC = 16;
    localparam int A_OUT = 2560;
    localparam int A_IN = 1536;
    localparam int B_OUT = 17920;
    localparam int B_IN = 16896;
    localparam int C_NEG = 32768;
    localparam int C_POS = 32256;
    localparam int BP_ONE = 1;
    localparam int BP_THREE = 3;
    function automatic int coef(input int v, input int f);
        return v >>> (COEF_FRAC - f);
    endfunction
endpackage

// File: rtl/lstm_act_pwq_seg.sv
// lstm_act_pwq_seg: classifies x into its sigmoid segment and selects a, b, c at FRAC_W.
module lstm_act_pwq_seg
    import lstm_act_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 7
) (
    input  logic signed [DATA_W-1:0] x,
    output logic signed [DATA_W-1:0] a,
    output logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] c
);
    localparam int P1 = BP_ONE << FRAC_W;
    localparam int P3 = BP_THREE << FRAC_W;
    localparam int ONE = 1 << FRAC_W;
    localparam int AO = coef(A_OUT, FRAC_W);
    localparam int AI = coef(A_IN, FRAC_W);
    localparam int NAO = coef(-A_OUT, FRAC_W);
    localparam int NAI = coef(-A_IN, FRAC_W);
    localparam int BO = coef(B_OUT, FRAC_W);
    localparam int BI = coef(B_IN, FRAC_W);
    localparam int CN = coef(C_NEG, FRAC_W);
    localparam int CP = coef(C_POS, FRAC_W);
    int xs;
    seg_e seg;
    assign xs = int'(x);
    // breakpoints belong to the lower segment
    assign seg = xs <= -P3 ? SEG_LO : xs <= -P1 ? SEG_N3N1 : xs <= 0 ? SEG_N1Z :
                 xs <= P1 ? SEG_ZP1 : xs <= P3 ? SEG_P1P3 : SEG_HI;
    assign a = DATA_W'(seg == SEG_N3N1 ? AO : seg == SEG_N1Z ? AI : seg == SEG_ZP1 ? NAI :
                       seg == SEG_P1P3 ? NAO : 0);
    assign b = DATA_W'(seg == SEG_N3N1 || seg == SEG_P1P3 ? BO : seg == SEG_N1Z || seg == SEG_ZP1 ? BI : 0);
    assign c = DATA_W'(seg == SEG_N3N1 || seg == SEG_N1Z ? CN : seg == SEG_ZP1 || seg == SEG_P1P3 ? CP :
                       seg == SEG_HI ? ONE : 0);
endmodule

// File: rtl/lstm_act_pwq.sv
// lstm_act_pwq: 3-stage piecewise-quadratic sigmoid/tanh activation with valid/ready and tag sideband.
// Tanh mode exists only when LSTM_ACT_TANH_EN is defined; otherwise the unit is sigmoid only.
module lstm_act_pwq
    import lstm_act_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 7,
    parameter int TAG_W = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_mode,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_mode,
    output logic [TAG_W-1:0]         out_tag
);
    localparam int PW = 2 * DATA_W;
    localparam int SW = DATA_W + 2;
    localparam logic signed [SW-1:0] ONE = SW'(1 << FRAC_W);
    logic en;
    logic v0, v1;
    act_mode_e mode_in, m0, m1;
    logic [TAG_W-1:0] t0, t1;
    logic signed [DATA_W-1:0] x_eff, a_sel, b_sel, c_sel, x0, a0, b0, c0, a1, c1, y;
    logic signed [PW-1:0] x2_1, bx1, ax2;
    logic signed [SW-1:0] sum, sig;
    assign en = !out_valid || out_ready;
    assign in_ready = en;
`ifdef LSTM_ACT_TANH_EN
    logic signed [SW:0] th;
    assign mode_in = act_mode_e'(in_mode);
    // 2x saturates when the two top bits disagree
    assign x_eff = mode_in == ACT_TANH
        ? (in_data[DATA_W-1] != in_data[DATA_W-2]
            ? {in_data[DATA_W-1], {(DATA_W-1){~in_data[DATA_W-1]}}}
            : {in_data[DATA_W-2:0], 1'b0})
        : in_data;
    assign th = {sig, 1'b0} - (SW+1)'(ONE);
    assign y = m1 == ACT_TANH ? DATA_W'(th) : DATA_W'(sig);
`else
    logic unused_mode;
    assign unused_mode = in_mode;
    assign mode_in = ACT_SIGMOID;
    assign x_eff = in_data;
    assign y = DATA_W'(sig);
`endif
    lstm_act_pwq_seg #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_seg (
        .x(x_eff),
        .a(a_sel),
        .b(b_sel),
        .c(c_sel)
    );
    assign ax2 = PW'(a1) * x2_1;
    assign sum = SW'(ax2 >>> FRAC_W) + SW'(bx1 >>> FRAC_W) + SW'(c1);
    assign sig = sum[SW-1] ? '0 : (sum > ONE ? ONE : sum);
    always_ff @(posedge clock) begin
        if (reset) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            out_valid <= 1'b0;
            out_data <= '0;
            out_mode <= 1'b0;
            out_tag <= '0;
        end else if (en) begin
            v0 <= in_valid;
            v1 <= v0;
            out_valid <= v1;
            out_data <= y;
            out_mode <= m1;
            out_tag <= t1;
        end
    end
    // data stages carry no reset; only the valids qualify them
    always_ff @(posedge clock) begin
        if (en) begin
            x0 <= x_eff;
            a0 <= a_sel;
            b0 <= b_sel;
            c0 <= c_sel;
            m0 <= mode_in;
            t0 <= in_tag;
            x2_1 <= (PW'(x0) * PW'(x0)) >>> FRAC_W;
            bx1 <= PW'(b0) * PW'(x0);
            a1 <= a0;
            c1 <= c0;
            m1 <= m0;
            t1 <= t0;
        end
    end
endmodule

// File: tb/tb_lstm_act_pwq.sv
// tb_lstm_act_pwq: scoreboard bench for lstm_act_pwq at DATA_W=16, FRAC_W=7, TAG_W=4.
module tb_lstm_act_pwq;
`ifdef LSTM_ACT_TANH_EN
    localparam bit TANH_EN = 1'b1;
`else
    localparam bit TANH_EN = 1'b0;
`endif
    typedef struct {
        int data;
        int tag;
        int mode;
    } exp_t;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic in_mode = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready, out_valid, out_mode;
    logic signed [15:0] in_data = '0;
    logic signed [15:0] out_data;
    logic [3:0] in_tag = '0;
    logic [3:0] out_tag;
    exp_t sb[$];
    exp_t e;
    int n_chk = 0;
    int n_pass = 0;
    int cur_exp = 0;
    int or_mode = 0;
    int ok_k = 0;
    int tag_n = 0;
    bit stalled = 1'b0;
    int prev_data, prev_tag, prev_mode;
    bit [3:0] pat = 4'b1001;
    int bnd[17] = '{-385, -384, -383, -129, -128, -127, -1, 0, 1, 127, 128, 129, 383, 384, 385, 32767, -32768};

    lstm_act_pwq dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_mode(in_mode),
        .in_tag(in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_mode(out_mode),
        .out_tag(out_tag)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int model(input int x, input bit m);
        int xe, a, b, c, s;
        bit t;
        t = TANH_EN && m;
        xe = t ? 2 * x : x;
        if (xe > 32767) xe = 32767;
        if (xe < -32768) xe = -32768;
        if (xe <= -384) s = 0;
        else if (xe > 384) s = 128;
        else begin
            if (xe <= -128) begin a = 5; b = 35; c = 64; end
            else if (xe <= 0) begin a = 3; b = 33; c = 64; end
            else if (xe <= 128) begin a = -3; b = 33; c = 63; end
            else begin a = -5; b = 35; c = 63; end
            s = ((a * ((xe * xe) >>> 7)) >>> 7) + ((b * xe) >>> 7) + c;
            s = s < 0 ? 0 : (s > 128 ? 128 : s);
        end
        return t ? 2 * s - 128 : s;
    endfunction

    task automatic send(input int x, input bit m, input int t, input int exp);
        bit acc;
        in_valid = 1'b1;
        in_data = 16'(x);
        in_mode = m;
        in_tag = 4'(t);
        cur_exp = exp;
        acc = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            #1;
            if (acc) return;
        end
        check("send_timeout", int'(acc), 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        or_mode = 0;
        for (int i = 0; i < 60 && sb.size() != 0; i++) begin
            @(posedge clock);
            #1;
        end
        idle(4);
        check("drain_empty", sb.size(), 0);
    endtask

    always @(posedge clock) begin
        #1;
        case (or_mode)
            1: begin
                out_ready = pat[ok_k];
                ok_k = (ok_k + 1) % 4;
            end
            2: out_ready = 1'($urandom_range(0, 1));
            3: out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    always @(negedge clock) begin
        if (reset) begin
            sb.delete();
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_data", int'(out_data), prev_data);
                check("stall_tag", int'(out_tag), prev_tag);
                check("stall_mode", int'(out_mode), prev_mode);
            end
            check("in_ready", int'(in_ready), int'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("spurious_out", int'(out_valid), 0);
                else begin
                    e = sb.pop_front();
                    check("out_data", int'(out_data), e.data);
                    check("out_tag", int'(out_tag), e.tag);
                    check("out_mode", int'(out_mode), e.mode);
                end
            end
            if (in_valid && in_ready)
                sb.push_back('{cur_exp, int'(in_tag), (TANH_EN && in_mode) ? 1 : 0});
            stalled = out_valid && !out_ready;
            prev_data = int'(out_data);
            prev_tag = int'(out_tag);
            prev_mode = int'(out_mode);
        end
    end

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_tag", int'(out_tag), 0);
        check("rst_mode", int'(out_mode), 0);
        check("rst_in_ready", int'(in_ready), 1);
        @(posedge clock);
        #1;
        send(0, 1'b0, 1, 64);
        in_valid = 1'b0;
        @(negedge clock);
        check("lat_c1", int'(out_valid), 0);
        @(negedge clock);
        check("lat_c2", int'(out_valid), 0);
        @(negedge clock);
        check("lat_c3", int'(out_valid), 1);
        idle(2);
        send(128, 1'b0, 2, 93);
        send(512, 1'b0, 3, 128);
        send(-384, 1'b0, 4, 0);
        send(384, 1'b0, 5, 123);
`ifdef LSTM_ACT_TANH_EN
        send(0, 1'b1, 6, 0);
        send(128, 1'b1, 7, 98);
        send(-1024, 1'b1, 8, -128);
`else
        send(128, 1'b1, 6, 93);
        send(-1024, 1'b1, 7, 0);
`endif
        drain();
        or_mode = 1;
        for (int i = 0; i < 8; i++) send(i * 100 - 350, 1'(i), i, model(i * 100 - 350, 1'(i)));
        idle(20);
        drain();
        for (int i = 0; i < 17; i++) begin
            send(bnd[i], 1'b0, tag_n, model(bnd[i], 1'b0));
            tag_n++;
            send(bnd[i], 1'b1, tag_n, model(bnd[i], 1'b1));
            tag_n++;
        end
        drain();
        or_mode = 2;
        for (int i = 0; i < 30; i++) begin
            int x;
            bit m;
            x = int'($urandom_range(0, 1400)) - 700;
            m = 1'($urandom_range(0, 1));
            send(x, m, i, model(x, m));
        end
        drain();
        or_mode = 3;
        idle(2);
        send(100, 1'b0, 10, model(100, 1'b0));
        send(-200, 1'b0, 11, model(-200, 1'b0));
        send(300, 1'b0, 12, model(300, 1'b0));
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        or_mode = 0;
        @(negedge clock);
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_data", int'(out_data), 0);
        @(posedge clock);
        #1;
        send(128, 1'b0, 13, 93);
        drain();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
